// File: rtl/bus_arbiter.sv
// Round-robin arbiter for one shared memory bus, with registered one-hot grants and one dead cycle between owners.
// Define ARB_TIMEOUT_EN to force a release after MAX_TENURE cycles, at a bus_ready boundary, when another core is waiting.
module bus_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int ID_W       = 2,
  parameter int MAX_TENURE = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] bus_rq,
  input  logic                 bus_ready,
  output logic [NUM_CORES-1:0] bus_grant,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id
);

  // state   | meaning
  // IDLE    | no owner, arbitrate every cycle
  // GRANT   | grant_id owns the bus
  // RELEASE | turnaround cycle, all grants low
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t               state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      win_id;
  logic                 win_found;
  logic [NUM_CORES-1:0] win_onehot;
  logic [ID_W-1:0]      next_ptr;
  logic                 timeout;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return ID_W'(s);
  endfunction

  // First set request at or above ptr, wrapping around.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!win_found && bus_rq[rr_index(ptr, i)]) begin
        win_found = 1'b1;
        win_id    = rr_index(ptr, i);
      end
    end
  end

  assign win_onehot = NUM_CORES'(1) << win_id;
  assign next_ptr   = (grant_id == ID_W'(NUM_CORES - 1)) ? '0 : grant_id + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] tenure;

  assign timeout = (tenure >= CNT_W'(MAX_TENURE)) && bus_ready && (|(bus_rq & ~bus_grant));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tenure <= '0;
    end else if (state == GRANT && bus_rq[grant_id] && !timeout) begin
      if (tenure != '1) tenure <= tenure + 1'b1;
    end else begin
      tenure <= '0;
    end
  end
`else
  logic unused_ready;
  assign unused_ready = bus_ready;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bus_grant   <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= '0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (win_found) begin
            state       <= GRANT;
            bus_grant   <= win_onehot;
            grant_valid <= 1'b1;
            grant_id    <= win_id;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (!bus_rq[grant_id] || timeout) begin
            state       <= RELEASE;
            bus_grant   <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= next_ptr;
          end
        end
        default: begin
          state       <= IDLE;
          bus_grant   <= '0;
          grant_valid <= 1'b0;
          grant_id    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with 4 cores and MAX_TENURE=4.
// Expectations follow ARB_TIMEOUT_EN when the bench is built with that macro.
module tb_bus_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] bus_rq;
  logic       bus_ready;
  logic [3:0] bus_grant;
  logic       grant_valid;
  logic [1:0] grant_id;

  int n_checks = 0;
  int n_pass   = 0;

  bus_arbiter #(.NUM_CORES(4), .ID_W(2), .MAX_TENURE(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus_rq      (bus_rq),
    .bus_ready   (bus_ready),
    .bus_grant   (bus_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_grant(input string tag, input logic [3:0] exp);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) if (exp[i]) id = 2'(i);
    check_val({tag, ".grant"}, 32'(bus_grant), 32'(exp));
    check_val({tag, ".valid"}, 32'(grant_valid), 32'(exp != 4'b0000));
    check_val({tag, ".id"}, 32'(grant_id), 32'(id));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus_rq    = 4'b0000;
    bus_ready = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] exp;
    logic [1:0] owner;

    do_reset();
    check_grant("reset", 4'b0000);

    // single requester, long hold, then release
    bus_rq = 4'b0100;
    tick();
    check_grant("t1_grant", 4'b0100);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i % 3 == 0) check_grant("t1_hold", 4'b0100);
    end
    bus_rq = 4'b0000;
    tick();
    check_grant("t1_release", 4'b0000);
    tick();
    check_grant("t1_idle", 4'b0000);

    // ptr is now 3: core 3 beats core 0, then priority wraps to core 0
    bus_rq = 4'b1001;
    tick();
    check_grant("t3_first", 4'b1000);
    tick();
    check_grant("t3_hold", 4'b1000);
    bus_rq = 4'b0001;
    tick();
    check_grant("t3_dead", 4'b0000);
    bus_rq = 4'b1001;
    tick();
    check_grant("t3_wrap", 4'b0001);
    bus_rq = 4'b0000;
    tick();
    tick();

    // all cores requesting, each owner drops for one cycle after three cycles
    do_reset();
    bus_rq = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      owner = 2'(k % 4);
      exp   = 4'b0001 << owner;
      check_grant($sformatf("t2_own%0d", k), exp);
      if (k == 4) break;
      tick();
      check_grant($sformatf("t2_hold%0d", k), exp);
      tick();
      check_grant($sformatf("t2_hold%0d", k), exp);
      bus_rq = 4'b1111 & ~exp;
      tick();
      check_grant($sformatf("t2_dead%0d", k), 4'b0000);
      bus_rq = 4'b1111;
      tick();
    end
    bus_rq = 4'b0000;
    tick();
    tick();

    // reset mid-grant drops grants asynchronously and restores ptr to 0
    do_reset();
    bus_rq = 4'b0010;
    tick();
    check_grant("t4_core1", 4'b0010);
    bus_rq = 4'b0011;
    tick();
    check_grant("t4_no_preempt", 4'b0010);
    #2 reset = 1'b1;
    #1 check_grant("t4_async", 4'b0000);
    @(negedge clock);
    reset = 1'b0;
    tick();
    check_grant("t4_after", 4'b0001);
    bus_rq = 4'b0000;
    tick();
    tick();

    // tenure timeout with a competing request
    do_reset();
    bus_rq = 4'b0001;
    tick();
    check_grant("t5_grant", 4'b0001);
    bus_rq = 4'b0101;
    for (int j = 1; j <= 6; j++) begin
      bus_ready = (j % 2 == 1);
`ifdef ARB_TIMEOUT_EN
      exp = (j <= 4) ? 4'b0001 : (j == 5) ? 4'b0000 : 4'b0100;
`else
      exp = 4'b0001;
`endif
      tick();
      check_grant($sformatf("t5_step%0d", j), exp);
    end
    bus_rq    = 4'b0000;
    bus_ready = 1'b0;
    tick();
    tick();

    // sole requester is never released, whatever bus_ready does
    do_reset();
    bus_rq = 4'b0001;
    for (int j = 0; j < 100; j++) begin
      bus_ready = j[0];
      tick();
      if (j % 10 == 0) check_grant($sformatf("t6_c%0d", j), 4'b0001);
    end
    check_val("t6_onehot", 32'($onehot0(bus_grant)), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
